mem_port_arbiter: RTL and testbench

Arbitrates the multicycle core's single unified memory port between two requesters: the CPU datapath (Adr/WriteData/MemWrite side) and a boot-loader/debug master. Serialises one word transaction at a time onto a single-port memory with a fixed read latency. Returns per-requester acknowledge and read data. Provides a stall indication the main controller uses to freeze PC/IR updates.

---
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the CPU datapath
// and a boot-loader/debug master, one word transaction at a time.
// Flow: IDLE -> ISSUE -> (WAIT x MEM_LAT, reads only) -> ACK -> IDLE.
// Optional macro ARB_RR_EN: round-robin arbitration instead of fixed loader
// priority with a BURST_MAX starvation limit.
//
// Handshake: a requester raises *_req with stable we/adr/wdata and holds them
// until its one-cycle *_ack pulse; it drops req on the edge that ends the ack
// cycle, or keeps it high with new fields to start a back-to-back transaction.
module mem_port_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MEM_LAT   = 1,
  parameter int BURST_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_adr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LAT - 1);

  state_t        r_state;
  state_t        w_next;
  logic          r_we;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic [CW-1:0] r_cnt;
  logic          r_owner;
  logic          w_pick_ldr;
  logic          w_grant;

`ifndef ARB_RR_EN
  localparam int SW = $clog2(BURST_MAX + 1);
  logic [SW-1:0] r_starve;
`endif

  assign w_grant = cpu_req | ldr_req;

  // Winner selection for a grant made in IDLE.
  always_comb begin
    w_pick_ldr = 1'b0;
    if (ldr_req && !cpu_req) begin
      w_pick_ldr = 1'b1;
    end else if (ldr_req && cpu_req) begin
`ifdef ARB_RR_EN
      w_pick_ldr = ~r_owner;
`else
      w_pick_ldr = (r_starve < SW'(BURST_MAX));
`endif
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_next = S_ISSUE;
      S_ISSUE: w_next = r_we ? S_ACK : S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Transaction latches, latency counter and read-data capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_owner <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_owner <= w_pick_ldr;
            r_we    <= w_pick_ldr ? ldr_we    : cpu_we;
            r_adr   <= w_pick_ldr ? ldr_adr   : cpu_adr;
            r_wdata <= w_pick_ldr ? ldr_wdata : cpu_wdata;
          end
        end
        S_ISSUE: begin
          if (!r_we) r_cnt <= LAT_M1;
        end
        S_WAIT: begin
          if (r_cnt == '0) r_rdata <= mem_rdata;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

`ifndef ARB_RR_EN
  // Consecutive loader grants taken while the CPU was kept waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve <= '0;
    end else if (r_state == S_IDLE && w_grant) begin
      if (w_pick_ldr && cpu_req) r_starve <= r_starve + SW'(1);
      else                       r_starve <= '0;
    end
  end
`endif

  // Output decode from state and latched transaction.
  always_comb begin
    mem_en    = (r_state == S_ISSUE);
    mem_we    = r_we;
    mem_adr   = r_adr;
    mem_wdata = r_wdata;
    cpu_ack   = (r_state == S_ACK) && !r_owner;
    ldr_ack   = (r_state == S_ACK) &&  r_owner;
    cpu_rdata = cpu_ack ? r_rdata : '0;
    ldr_rdata = ldr_ack ? r_rdata : '0;
    cpu_stall = cpu_req & ~cpu_ack;
    busy      = (r_state != S_IDLE);
    owner     = r_owner;
    dbg_state = r_state;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model, directed
// arbitration order, randomized traffic, reset during a read wait.
module tb_mem_port_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LAT   = 3;
  localparam int BURST = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          cpu_req, cpu_we, ldr_req, ldr_we;
  logic [AW-1:0] cpu_adr, ldr_adr;
  logic [DW-1:0] cpu_wdata, ldr_wdata, mem_rdata;
  logic [DW-1:0] cpu_rdata, ldr_rdata, mem_wdata;
  logic          cpu_ack, ldr_ack, cpu_stall, mem_en, mem_we, busy, owner;
  logic [AW-1:0] mem_adr;
  logic [1:0]    dbg_state;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .BURST_MAX(BURST)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_adr(ldr_adr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // values applied at the start of the next cycle
  logic          n_reset;
  logic          n_cpu_req, n_cpu_we, n_ldr_req, n_ldr_we;
  logic [AW-1:0] n_cpu_adr, n_ldr_adr;
  logic [DW-1:0] n_cpu_wdata, n_ldr_wdata;

  // reference model: one transaction described by its issue/ack cycles
  int            m_issue, m_ack, m_next, m_streak;
  logic          m_we, m_win, m_owner;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_wdata, m_rd;

  int mode;       // 0 = directed (counted back-to-back), 1 = random
  int cpu_left, ldr_left;

  // scoreboard of the order in which acknowledges appear (0 = CPU, 1 = loader)
  logic [0:0] exp_q[$];
  logic [0:0] got_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_issue  = -100;
    m_ack    = -100;
    m_next   = 0;
    m_streak = 0;
    m_we     = 1'b0;
    m_win    = 1'b0;
    m_owner  = 1'b0;
    m_adr    = '0;
    m_wdata  = '0;
    m_rd     = '0;
  endtask

  task automatic new_cpu_op();
    n_cpu_req = 1'b1;
    if (mode == 1) begin
      n_cpu_we    = 1'($urandom_range(0, 1));
      n_cpu_adr   = $urandom;
      n_cpu_wdata = $urandom;
    end else begin
      n_cpu_we    = 1'b0;
      n_cpu_adr   = 32'h10;
      n_cpu_wdata = '0;
    end
  endtask

  task automatic new_ldr_op();
    n_ldr_req = 1'b1;
    if (mode == 1) begin
      n_ldr_we    = 1'($urandom_range(0, 1));
      n_ldr_adr   = $urandom;
      n_ldr_wdata = $urandom;
    end else begin
      n_ldr_we    = 1'b1;
      n_ldr_adr   = 32'h100 + 32'(ldr_left);
      n_ldr_wdata = $urandom;
    end
  endtask

  // driver + model + checks for one clock cycle
  task automatic step();
    int   c;
    logic in_txn, exp_ca, exp_la, w, cont;
    @(posedge clk);
    #1;
    cyc++;
    c         = cyc;
    reset     = n_reset;
    cpu_req   = n_cpu_req;  cpu_we = n_cpu_we;  cpu_adr = n_cpu_adr;  cpu_wdata = n_cpu_wdata;
    ldr_req   = n_ldr_req;  ldr_we = n_ldr_we;  ldr_adr = n_ldr_adr;  ldr_wdata = n_ldr_wdata;
    mem_rdata = $urandom;
    @(negedge clk);
    if (!reset) begin
      chk("rst_busy", busy, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_cpu_ack", cpu_ack, 0);
      chk("rst_ldr_ack", ldr_ack, 0);
      return;
    end
    in_txn = (c >= m_issue) && (c <= m_ack);
    exp_ca = (c == m_ack) && !m_win;
    exp_la = (c == m_ack) &&  m_win;
    if (in_txn && !m_we && c == m_issue + LAT) m_rd = mem_rdata;
    chk("mem_en", mem_en, (c == m_issue));
    chk("busy", busy, in_txn);
    chk("owner", owner, m_owner);
    chk("cpu_ack", cpu_ack, exp_ca);
    chk("ldr_ack", ldr_ack, exp_la);
    chk("cpu_stall", cpu_stall, cpu_req & ~exp_ca);
    if (in_txn) begin
      chk("mem_we", mem_we, m_we);
      chk("mem_adr", mem_adr, m_adr);
      chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (exp_ca && !m_we) chk("cpu_rdata", cpu_rdata, m_rd);
    if (exp_la && !m_we) chk("ldr_rdata", ldr_rdata, m_rd);
    if (exp_ca) chk("ldr_rdata_idle", ldr_rdata, 0);
    if (exp_la) chk("cpu_rdata_idle", cpu_rdata, 0);
    if (cpu_ack) got_q.push_back(1'b0);
    if (ldr_ack) got_q.push_back(1'b1);

    // grant decision for the request sampled at the end of this cycle
    if (c >= m_next && (cpu_req || ldr_req)) begin
      if (!cpu_req)      w = 1'b1;
      else if (!ldr_req) w = 1'b0;
      else begin
`ifdef ARB_RR_EN
        w = !m_owner;
`else
        w = (m_streak < BURST);
`endif
      end
      m_streak = (w && cpu_req) ? m_streak + 1 : 0;
      m_win    = w;
      m_owner  = w;
      m_we     = w ? ldr_we    : cpu_we;
      m_adr    = w ? ldr_adr   : cpu_adr;
      m_wdata  = w ? ldr_wdata : cpu_wdata;
      m_issue  = c + 1;
      m_ack    = m_we ? c + 2 : c + 2 + LAT;
      m_next   = m_ack + 1;
    end

    // requester behaviour for the next cycle
    if (c == m_ack && !m_win) begin
      cont = 1'b0;
      if (mode == 1) cont = ($urandom_range(0, 1) == 1);
      else if (cpu_left > 0) begin cont = 1'b1; cpu_left--; end
      if (cont) new_cpu_op(); else n_cpu_req = 1'b0;
    end else if (!n_cpu_req && mode == 1) begin
      if ($urandom_range(0, 2) == 0) new_cpu_op();
    end
    if (c == m_ack && m_win) begin
      cont = 1'b0;
      if (mode == 1) cont = ($urandom_range(0, 1) == 1);
      else if (ldr_left > 0) begin cont = 1'b1; ldr_left--; end
      if (cont) new_ldr_op(); else n_ldr_req = 1'b0;
    end else if (!n_ldr_req && mode == 1) begin
      if ($urandom_range(0, 2) == 0) new_ldr_op();
    end
  endtask

  task automatic drain(input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (!n_cpu_req && !n_ldr_req && cyc > m_ack) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_idle", done, 1);
  endtask

  initial begin
    int   rel, ack_c;
    logic found;
    // reset state
    reset = 1'b0; n_reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_adr = '0; cpu_wdata = '0;
    ldr_req = 0; ldr_we = 0; ldr_adr = '0; ldr_wdata = '0;
    mem_rdata = '0;
    n_cpu_req = 0; n_cpu_we = 0; n_cpu_adr = '0; n_cpu_wdata = '0;
    n_ldr_req = 0; n_ldr_we = 0; n_ldr_adr = '0; n_ldr_wdata = '0;
    mode = 0; cpu_left = 0; ldr_left = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mem_en", mem_en, 0);
    chk("reset_mem_we", mem_we, 0);
    chk("reset_mem_adr", mem_adr, 0);
    chk("reset_mem_wdata", mem_wdata, 0);
    chk("reset_cpu_ack", cpu_ack, 0);
    chk("reset_ldr_ack", ldr_ack, 0);
    chk("reset_cpu_rdata", cpu_rdata, 0);
    chk("reset_ldr_rdata", ldr_rdata, 0);
    chk("reset_busy", busy, 0);
    chk("reset_owner", owner, 0);
    chk("reset_stall", cpu_stall, 0);
    chk("reset_state", dbg_state, 0);

    // directed arbitration order straight out of reset
    n_reset = 1'b1;
    got_q.delete();
`ifdef ARB_RR_EN
    ldr_left = 3; new_ldr_op();
    cpu_left = 3; new_cpu_op();
    for (int i = 0; i < 4; i++) begin exp_q.push_back(1'b1); exp_q.push_back(1'b0); end
`else
    ldr_left = 10; new_ldr_op(); ldr_left = 9;
    cpu_left = 0;  new_cpu_op();
    for (int i = 0; i < 8; i++) exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
`endif
    drain(200);
    chk("grant_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk($sformatf("grant_%0d", i), got_q[i], exp_q[i]);
    end

    // randomized mixed traffic
    mode = 1;
    repeat (1500) step();
    mode = 0; cpu_left = 0; ldr_left = 0;
    drain(60);

    // reset asserted while a CPU read waits on memory
    new_cpu_op();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cyc == m_issue + 1 && !m_we && !m_win) begin found = 1'b1; break; end
    end
    chk("reach_wait", found, 1);
    #2;
    reset = 1'b0; n_reset = 1'b0;
    #1;
    chk("midrst_mem_en", mem_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cpu_ack", cpu_ack, 0);
    chk("midrst_ldr_ack", ldr_ack, 0);
    chk("midrst_owner", owner, 0);
    chk("midrst_mem_adr", mem_adr, 0);
    chk("midrst_stall", cpu_stall, 1);
    model_reset();
    step();
    n_reset = 1'b1;
    rel   = cyc + 1;
    ack_c = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cpu_ack) begin ack_c = cyc; break; end
    end
    chk("reack_latency", ack_c - rel, 2 + LAT);
    drain(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // global time bound
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
